// File: rtl/uart_rx.sv
// 8N1 UART receiver: 3-flop input synchronizer, mid-bit sampling and framing-error
// detection, with break handling that holds off start detection until the line returns high.
module uart_rx #(
    parameter logic [12:0] BAUD_CNT_MAX = 13'd5207
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_data_flag,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [12:0] BAUD_MID = BAUD_CNT_MAX / 13'd2;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  sync_q;
    logic        rx_s;
    logic        rx_prev;
    logic        start_cond;
    logic        mid;
    logic        frame_active;
    logic [12:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;

    // Flops reset to 1 so a reset release never looks like a falling edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q  <= 3'b111;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[1:0], rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s         = sync_q[2];
    assign start_cond   = rx_prev & ~rx_s;
    assign mid          = (baud_cnt == BAUD_MID);
    assign frame_active = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_cond) state_d = START;
            START:     if (mid) state_d = rx_s ? IDLE : DATA;
            DATA:      if (mid && (bit_idx == 3'd7)) state_d = STOP;
            STOP:      if (mid) state_d = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt <= 13'd0;
        end else if (!frame_active || (baud_cnt == BAUD_CNT_MAX)) begin
            baud_cnt <= 13'd0;
        end else begin
            baud_cnt <= baud_cnt + 13'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_idx <= 3'd0;
            shift_q <= 8'h00;
        end else if (state_q != DATA) begin
            bit_idx <= 3'd0;
        end else if (mid) begin
            bit_idx <= bit_idx + 3'd1;
            shift_q <= {rx_s, shift_q[7:1]};
        end
    end

    // Outputs are registered off the stop-bit mid-sample.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            po_data      <= 8'h00;
            po_data_flag <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            po_data_flag <= (state_q == STOP) && mid && rx_s;
            frame_err    <= (state_q == STOP) && mid && !rx_s;
            if ((state_q == STOP) && mid && rx_s) begin
                po_data <= shift_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: a table of frames plus
// hand-written glitch, framing-error/break and mid-frame reset sequences.
module tb_uart_rx;

    localparam logic [12:0] BAUD_MAX = 13'd15;
    localparam int          BIT_CYC  = 16;
    localparam int          LATENCY  = 3 + 9 * 16 + 7 + 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       rx;
    logic [7:0] po_data;
    logic       po_data_flag;
    logic       frame_err;

    uart_rx #(.BAUD_CNT_MAX(BAUD_MAX)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx           (rx),
        .po_data      (po_data),
        .po_data_flag (po_data_flag),
        .frame_err    (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int compared = 0;
    int failed = 0;
    int cyc = 0;
    int flag_cnt = 0;
    int err_cnt = 0;
    int last_flag_cyc = 0;
    int start_cyc = 0;
    logic flag_d = 1'b0;
    logic err_d = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge sys_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        start_cyc = cyc;
        wait_cycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cycles(BIT_CYC);
        end
        rx = stop_bit;
        wait_cycles(BIT_CYC);
    endtask

    // Monitor and scoreboard
    always @(negedge sys_clk) begin
        if (po_data_flag) begin
            flag_cnt++;
            last_flag_cyc = cyc;
            if (exp_q.size() == 0) begin
                compared++;
                failed++;
                $display("FAIL unexpected_flag: got po_data %0h expected no flag", po_data);
            end else begin
                check("scoreboard_po_data", {24'd0, po_data}, {24'd0, exp_q.pop_front()});
            end
            check("flag_width", {31'd0, flag_d}, 32'd0);
        end
        if (frame_err) begin
            err_cnt++;
            check("err_width", {31'd0, err_d}, 32'd0);
        end
        if (po_data_flag || frame_err) begin
            check("flag_err_exclusive", {31'd0, po_data_flag & frame_err}, 32'd0);
        end
        flag_d = po_data_flag;
        err_d  = frame_err;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle;
        int         exp_flags;
        int         exp_errs;
        logic [7:0] exp_po;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int f0, e0, lat;

        vecs[0] = '{8'h55, 1'b1, 20, 1, 0, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 0,  1, 0, 8'hA3};
        vecs[2] = '{8'h0F, 1'b1, 20, 1, 0, 8'h0F};
        vecs[3] = '{8'h00, 1'b1, 20, 1, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 20, 1, 0, 8'hFF};

        sys_rst_n = 1'b0;
        rx        = 1'b1;
        wait_cycles(3);
        check("reset_po_data", {24'd0, po_data}, 32'h00);
        check("reset_flag", {31'd0, po_data_flag}, 32'd0);
        check("reset_err", {31'd0, frame_err}, 32'd0);
        check("reset_state", {29'd0, 3'(dut.state_q)}, 32'd0);
        sys_rst_n = 1'b1;
        wait_cycles(10);

        for (int i = 0; i < 5; i++) begin
            f0 = flag_cnt;
            e0 = err_cnt;
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            rx = 1'b1;
            wait_cycles(vecs[i].idle);
            check($sformatf("vec%0d_flags", i), flag_cnt - f0, vecs[i].exp_flags);
            check($sformatf("vec%0d_errs", i), err_cnt - e0, vecs[i].exp_errs);
            check($sformatf("vec%0d_po_data", i), {24'd0, po_data}, {24'd0, vecs[i].exp_po});
            if (vecs[i].exp_flags == 1) begin
                lat = last_flag_cyc - start_cyc;
                compared++;
                if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
                    failed++;
                    $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, LATENCY);
                end
            end
        end

        // Short low glitch must be rejected at the start-bit mid-sample
        f0 = flag_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(30);
        check("glitch_flags", flag_cnt - f0, 0);
        check("glitch_errs", err_cnt - e0, 0);
        check("glitch_state_idle", {29'd0, 3'(dut.state_q)}, 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        rx = 1'b1;
        wait_cycles(20);
        check("after_glitch_flags", flag_cnt - f0, 1);
        check("after_glitch_po_data", {24'd0, po_data}, 32'h3C);

        // Framing error followed by a held-low line (break)
        f0 = flag_cnt;
        e0 = err_cnt;
        send_frame(8'h81, 1'b0);
        wait_cycles(20);
        check("break_state_wait_high", {29'd0, 3'(dut.state_q)}, 32'd4);
        wait_cycles(20);
        check("ferr_count", err_cnt - e0, 1);
        check("ferr_flags", flag_cnt - f0, 0);
        check("ferr_po_data_kept", {24'd0, po_data}, 32'h3C);
        rx = 1'b1;
        wait_cycles(16);
        check("break_no_false_start", err_cnt - e0, 1);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        rx = 1'b1;
        wait_cycles(20);
        check("after_break_flags", flag_cnt - f0, 1);
        check("after_break_po_data", {24'd0, po_data}, 32'h7E);

        // Reset during data bit 4 of 0xFF
        f0 = flag_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        wait_cycles(BIT_CYC);
        rx = 1'b1;
        wait_cycles(4 * BIT_CYC + 8);
        sys_rst_n = 1'b0;
        wait_cycles(2);
        check("midreset_po_data", {24'd0, po_data}, 32'h00);
        check("midreset_flag", {31'd0, po_data_flag}, 32'd0);
        check("midreset_err", {31'd0, frame_err}, 32'd0);
        check("midreset_state", {29'd0, 3'(dut.state_q)}, 32'd0);
        wait_cycles(3);
        sys_rst_n = 1'b1;
        wait_cycles(40);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        rx = 1'b1;
        wait_cycles(20);
        check("postreset_flags", flag_cnt - f0, 1);
        check("postreset_errs", err_cnt - e0, 0);
        check("postreset_po_data", {24'd0, po_data}, 32'h12);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
